dtc_edge_gen: RTL

- Digital-to-time converter. It is the transmit-side counterpart of the time-to-digital converter.
- It accepts an 8-bit code and produces one comparator-style rising edge per conversion frame. The edge occurs at the counter value the TDC decodes back to that code.
- Frame timing is identical to the TDC: a WIDTH-bit down-counter drives the capacitor-reset phase from its MSB.
- Used as a closed-loop stimulus for the TDC ("in" input) and as an on-chip calibration source.

---
 rtl/dtc_edge_gen.sv | 100 ++++++++++
 1 files changed

// File: rtl/dtc_edge_gen.sv
// dtc_edge_gen: digital-to-time converter, one comparator edge per frame.
// Optional macro DTC_REPEAT_LAST_EN: repeat last code on an empty boundary.
module dtc_edge_gen #(
  parameter int WIDTH  = 11,
  parameter int CODE_W = 8,
  parameter int OFFSET = 509
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  output logic              cmp_out,
  output logic              rst_cap,
  output logic              frame_start,
  output logic              underrun
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]  r_cnt;
  logic [CODE_W-1:0] r_pend;
  logic              r_pend_full;
  logic [CODE_W-1:0] r_act;
  logic              r_act_valid;
  logic              r_cmp;
  logic              r_und;

  logic [WIDTH-1:0]  w_cnt_nxt;
  logic [WIDTH-1:0]  w_target;
  logic              w_wrap;
  logic              w_hs;
  logic              w_hit;

  assign w_cnt_nxt = r_cnt - 1'b1;
  assign w_wrap    = (r_cnt == '0);
  assign w_target  = WIDTH'(OFFSET) + WIDTH'(r_act);
  assign w_hs      = code_valid & code_ready;
  // Edge lands on the cycle the counter becomes the target value
  assign w_hit     = r_act_valid & ~w_wrap
                   & (w_cnt_nxt == w_target);

  assign code_ready  = rst & ~r_pend_full;
  assign cmp_out     = r_cmp;
  assign rst_cap     = r_cnt[WIDTH-1];
  assign frame_start = (r_cnt == CNT_MAX);
  assign underrun    = r_und;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= CNT_MAX;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_act       <= '0;
      r_act_valid <= 1'b0;
      r_und       <= 1'b0;
    end else if (w_wrap) begin
      r_und <= 1'b0;
      if (r_pend_full) begin
        r_act       <= r_pend;
        r_act_valid <= 1'b1;
        r_pend_full <= 1'b0;
      end else if (w_hs) begin
        r_act       <= code_in;
        r_act_valid <= 1'b1;
      end else begin
        r_und <= 1'b1;
`ifdef DTC_REPEAT_LAST_EN
        r_act_valid <= r_act_valid;
`else
        r_act_valid <= 1'b0;
`endif
      end
    end else begin
      r_und <= 1'b0;
      if (w_hs) begin
        r_pend      <= code_in;
        r_pend_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cmp <= 1'b0;
    end else if (w_wrap) begin
      r_cmp <= 1'b0;
    end else if (w_hit) begin
      r_cmp <= 1'b1;
    end
  end

endmodule
